// File: rtl/vga_sync.sv
// 640x480@60 Hz raster timing generator for the text display path.
// Coordinates, sync levels and strobes are all registered together so they stay aligned.
module vga_sync #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic       clk25mhz,
  input  logic       reset,
  input  logic       enable,
  output logic [9:0] hindex,
  output logic [9:0] vindex,
  output logic       hsync,
  output logic       vsync,
  output logic       visible,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > 1024) begin : g_h_total_chk
    $error("vga_sync: H_TOTAL exceeds 1024");
  end
  if (V_TOTAL > 1024) begin : g_v_total_chk
    $error("vga_sync: V_TOTAL exceeds 1024");
  end

  localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  // Region bounds are 11 bits wide so an end bound of exactly 1024 is still representable.
  localparam logic [10:0] H_VIS_END = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS_END = 11'(V_VISIBLE);
  localparam logic [10:0] HS_BEG    = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END    = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_BEG    = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END    = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       visible_q, visible_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic [7:0] fcnt_q, fcnt_d;
  logic       first_q, first_d;

  // Next raster position and the flags describing that position.
  always_comb begin
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    hsync_d       = ~SYNC_ACTIVE;
    vsync_d       = ~SYNC_ACTIVE;
    visible_d     = 1'b0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    fcnt_d        = fcnt_q;
    first_d       = first_q;

    // ">=" rather than "==" pulls any out-of-range count straight back to the origin.
    if (hcnt_q >= H_LAST) begin
      hcnt_d = 10'd0;
      if (vcnt_q >= V_LAST) begin
        vcnt_d = 10'd0;
      end else begin
        vcnt_d = vcnt_q + 10'd1;
      end
    end else begin
      hcnt_d = hcnt_q + 10'd1;
      vcnt_d = vcnt_q;
    end

    if (({1'b0, hcnt_d} >= HS_BEG) && ({1'b0, hcnt_d} < HS_END)) begin
      hsync_d = SYNC_ACTIVE;
    end else begin
      hsync_d = ~SYNC_ACTIVE;
    end

    if (({1'b0, vcnt_d} >= VS_BEG) && ({1'b0, vcnt_d} < VS_END)) begin
      vsync_d = SYNC_ACTIVE;
    end else begin
      vsync_d = ~SYNC_ACTIVE;
    end

    visible_d     = ({1'b0, hcnt_d} < H_VIS_END) && ({1'b0, vcnt_d} < V_VIS_END);
    line_start_d  = (hcnt_d == 10'd0);
    frame_start_d = line_start_d && (vcnt_d == 10'd0);

    // The frame entered straight out of reset is frame 0, so its start does not count.
    if (frame_start_d) begin
      first_d = 1'b0;
      if (first_q) begin
        fcnt_d = fcnt_q;
      end else begin
        fcnt_d = fcnt_q + 8'd1;
      end
    end else begin
      first_d = first_q;
      fcnt_d  = fcnt_q;
    end
  end

  // State register: reset dominates, otherwise advance only when enabled.
  always_ff @(posedge clk25mhz) begin
    if (reset) begin
      hcnt_q        <= H_LAST;
      vcnt_q        <= V_LAST;
      hsync_q       <= ~SYNC_ACTIVE;
      vsync_q       <= ~SYNC_ACTIVE;
      visible_q     <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      fcnt_q        <= 8'd0;
      first_q       <= 1'b1;
    end else if (enable) begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      visible_q     <= visible_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      fcnt_q        <= fcnt_d;
      first_q       <= first_d;
    end
  end

  assign hindex      = hcnt_q;
  assign vindex      = vcnt_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign visible     = visible_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = fcnt_q;

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: a default-timing instance plus a shrunken-timing instance (inverted
// sync polarity) so multi-frame behaviour fits in a short run.
module tb_vga_sync;

  typedef struct {
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       vis;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } exp_t;

  localparam int FR1 = 16 * 11;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [9:0] h0, v0, h1, v1;
  logic       hs0, vs0, vis0, ls0, fs0;
  logic       hs1, vs1, vis1, ls1, fs1;
  logic [7:0] fc0, fc1;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint n        = 0;
  bit     checking = 1'b0;

  always #20 clk = ~clk;

  vga_sync u_d0 (
    .clk25mhz(clk), .reset(reset), .enable(enable),
    .hindex(h0), .vindex(v0), .hsync(hs0), .vsync(vs0), .visible(vis0),
    .line_start(ls0), .frame_start(fs0), .frame_count(fc0)
  );

  vga_sync #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .SYNC_ACTIVE(1'b1)
  ) u_d1 (
    .clk25mhz(clk), .reset(reset), .enable(enable),
    .hindex(h1), .vindex(v1), .hsync(hs1), .vsync(vs1), .visible(vis1),
    .line_start(ls1), .frame_start(fs1), .frame_count(fc1)
  );

  // Expected outputs after n enabled edges since the last reset, from raster arithmetic.
  function automatic exp_t model(input longint cnt, input int hv, input int hf, input int hsw,
                                 input int hb, input int vv, input int vf, input int vsw,
                                 input int vb, input bit sa);
    exp_t   e;
    longint ht, vt, pos, h, v;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    if (cnt == 0) begin
      e.h = 10'(ht - 1); e.v = 10'(vt - 1);
      e.hs = ~sa; e.vs = ~sa; e.vis = 1'b0; e.ls = 1'b0; e.fs = 1'b0; e.fc = 8'd0;
    end else begin
      pos = (cnt - 1) % (ht * vt);
      h = pos % ht;
      v = pos / ht;
      e.h   = 10'(h);
      e.v   = 10'(v);
      e.hs  = (h >= hv + hf && h < hv + hf + hsw) ? sa : ~sa;
      e.vs  = (v >= vv + vf && v < vv + vf + vsw) ? sa : ~sa;
      e.vis = (h < hv) && (v < vv);
      e.ls  = (h == 0);
      e.fs  = (h == 0) && (v == 0);
      e.fc  = 8'(((cnt - 1) / (ht * vt)) % 256);
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input bit r, input bit e);
    reset  = r;
    enable = e;
    @(posedge clk);
    #1;
  endtask

  // Reference position counter.
  always @(posedge clk) begin
    if (reset) begin
      n        <= 0;
      checking <= 1'b1;
    end else if (enable) begin
      n <= n + 1;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    exp_t e0, e1;
    if (checking) begin
      e0 = model(n, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
      e1 = model(n, 8, 2, 3, 3, 6, 1, 2, 2, 1'b1);
      check("d0_hindex", h0, e0.h);       check("d0_vindex", v0, e0.v);
      check("d0_hsync", hs0, e0.hs);      check("d0_vsync", vs0, e0.vs);
      check("d0_visible", vis0, e0.vis);  check("d0_line_start", ls0, e0.ls);
      check("d0_frame_start", fs0, e0.fs); check("d0_frame_count", fc0, e0.fc);
      check("d0_h_range", h0 < 10'd800, 1);
      check("d0_v_range", v0 < 10'd525, 1);
      check("d1_hindex", h1, e1.h);       check("d1_vindex", v1, e1.v);
      check("d1_hsync", hs1, e1.hs);      check("d1_vsync", vs1, e1.vs);
      check("d1_visible", vis1, e1.vis);  check("d1_line_start", ls1, e1.ls);
      check("d1_frame_start", fs1, e1.fs); check("d1_frame_count", fc1, e1.fc);
      check("d1_h_range", h1 < 10'd16, 1);
      check("d1_v_range", v1 < 10'd11, 1);
    end
  end

  initial begin
    int guard;
    reset  = 1'b1;
    enable = 1'b0;

    repeat (3) tick(1'b1, 1'b0);
    check("rst_h", h0, 799);  check("rst_v", v0, 524);
    check("rst_hs", hs0, 1);  check("rst_vs", vs0, 1);
    check("rst_vis", vis0, 0); check("rst_fs", fs0, 0);
    check("rst_fc", fc0, 0);  check("rst_d1_hs", hs1, 0);

    tick(1'b0, 1'b1);
    check("first_h", h0, 0);   check("first_v", v0, 0);
    check("first_fs", fs0, 1); check("first_ls", ls0, 1);
    check("first_vis", vis0, 1); check("first_hs", hs0, 1);
    check("first_vs", vs0, 1); check("first_fc", fc0, 0);

    repeat (639) tick(1'b0, 1'b1);
    check("pre_stall_h", h0, 639);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0);
      check("stall_h", h0, 639);
      check("stall_vis", vis0, 1);
    end
    tick(1'b0, 1'b1);
    check("resume_h", h0, 640);
    check("resume_vis", vis0, 0);

    guard = 0;
    while (!(h0 == 10'd300 && v0 == 10'd1) && guard < 2000) begin
      tick(1'b0, 1'b1);
      guard++;
    end
    check("reach_300_1", guard < 2000, 1);
    tick(1'b1, 1'b0);
    check("midrst_h", h0, 799); check("midrst_v", v0, 524); check("midrst_fc", fc0, 0);
    tick(1'b0, 1'b1);
    check("rel_h", h0, 0); check("rel_v", v0, 0); check("rel_fs", fs0, 1);

    // Long run with random stalls on the small raster: 257 frames.
    tick(1'b1, 1'b0);
    guard = 0;
    while (n < 256 * FR1 && guard < 70000) begin
      tick(1'b0, $urandom_range(0, 7) != 0);
      guard++;
    end
    check("frames_reached", guard < 70000, 1);
    check("wrap_pre_fc", fc1, 255);
    tick(1'b0, 1'b1);
    check("wrap_fc", fc1, 0);
    check("wrap_fs", fs1, 1);
    check("wrap_h", h1, 0);
    check("wrap_v", v1, 0);

    // Random resets and stalls.
    repeat (1500) tick($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
